stream_sink: RTL and testbench
==============================

# stream_sink

Wishbone responder for the video stream master of the hardware-support block: accepts pixel writes, buffers them in a small FIFO, and replays them as Wishbone writes into the SDRAM framebuffer through the interconnect. It replaces the constant-ack tie-off on the stream bus. A linear pixel counter generates framebuffer addresses. A start-of-frame write resynchronises that counter.

## Interface
- HDISP, 800: pixels per line.
- VDISP, 480: lines per frame.
- FIFO_DEPTH, 16: buffer depth in words, power of two, ≥2.
- BASE_ADR, 32'h0: framebuffer byte base address.

- sys_clk  in  1  system clock (100 MHz), same clock as both Wishbone interfaces
- sys_rst  in  1  reset sys_rst, asynchronous, active-high; clock sys_clk
- wshb_ifs  slave modport  wshb_if DATA_BYTES=4  stream side (responder)
- wshb_ifm  master modport  wshb_if DATA_BYTES=4  SDRAM/intercon side (initiator)
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is acknowledged by SDRAM

## Operation
- FIFO entry = {sof, dat[31:0]}; sof = (wshb_ifs.adr == 0) at push.
- Slave, combinational: ack = cyc & stb & we & !full; err = cyc & stb & !we (reads unsupported); rty = 0; dat_sm = 0. Push on ack. adr is used only for sof; sel is ignored.
- full/empty derive from the registered level (0..FIFO_DEPTH). A pop in the same cycle does not unblock a push when full.
- Master FSM, states IDLE and WRITE:
  - IDLE: if level>0 → WRITE next cycle with cyc=stb=we=1, sel=4'hF.
  - WRITE: dat_ms = FIFO head data; adr = BASE_ADR + 4*(head.sof ? 0 : pix_cnt).
  - WRITE, on ack or err: pop the FIFO; pix_cnt ← (head.sof ? 1 : pix_cnt+1), wrapping to 0 at HDISP*VDISP.
    - If the remaining level after pop and push is >0, stay in WRITE.
    - Otherwise go to IDLE and drop cyc/stb the next cycle.
  - WRITE, on rty: no pop; re-present the same word.
- err from SDRAM drops the word but still advances pix_cnt.
- frame_done pulses on the pop whose effective index = HDISP*VDISP-1.
- pix_cnt width = $clog2(HDISP*VDISP). Address arithmetic is 32-bit unsigned.

## Timing
- Reset values: cyc, stb, we = 0; adr = 0; dat_ms = 0; sel = 0; cti = 0; bte = 0; frame_done = 0; level = 0; pix_cnt = 0; state = IDLE.
- Slave ack carries 0 added latency. Sustained rate is 1 word/cycle while not full.
- First master stb appears 1 cycle after the first push (IDLE→WRITE registered).
- Master back-to-back writes proceed at 1 word/cycle while SDRAM acks each cycle.
- Reset asserted mid-transfer: cyc/stb drop immediately; FIFO is flushed; the in-flight word is lost.
- Simultaneous push and pop: level unchanged; data order is preserved.
- The stream master is stalled (ack held low) for as long as full=1.

## Configuration
- STREAM_SINK_BURST_EN
  - Defined: master drives cti=3'b010 (incrementing burst) while more than one word remains, and cti=3'b111 on the last word; bte=2'b00. A sof word always ends the current burst first: the preceding word carries cti=3'b111, and the sof word starts a new burst.
  - Undefined: cti=3'b000 (classic) on every cycle; bte=0.

## Test plan
- Reset, then a single write adr=0 dat=32'h00FF0000 → slave ack in the same cycle; 1 cycle later master adr=BASE_ADR, dat=32'h00FF0000, sel=4'hF; after SDRAM ack, cyc=0 and pix_cnt=1.
- SDRAM ack held low, 17 stream writes → acks 1–16 in consecutive cycles, 17th held until the first SDRAM ack; then 17th ack; all words arrive in order with adr incrementing by 4.
- Stream a full frame of HDISP*VDISP writes, first with adr=0 → frame_done pulses exactly once, on the last ack; adr of the next non-sof word = BASE_ADR.
- Mid-frame sof: after 100 pixels, write with adr=0 → that word goes to BASE_ADR; the following word goes to BASE_ADR+4.
- SDRAM rty on word 3, then ack → word 3 presented twice; no loss or duplication downstream.
- Stream read (we=0) → err=1 and ack=0 in the same cycle; no push.
- With STREAM_SINK_BURST_EN defined, 4 queued words → cti sequence 010, 010, 010, 111.

Source files
------------

// File: rtl/stream_sink.sv
// Wishbone stream responder: FIFO-buffers pixel writes and replays them as SDRAM framebuffer writes.
// Define STREAM_SINK_BURST_EN to tag master cycles as incrementing bursts (cti 010/111).
`timescale 1ns/1ps
module stream_sink #(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  // stream side (responder)
  input  logic        wshb_ifs_cyc,
  input  logic        wshb_ifs_stb,
  input  logic        wshb_ifs_we,
  input  logic [31:0] wshb_ifs_adr,
  input  logic [31:0] wshb_ifs_dat_ms,
  input  logic [3:0]  wshb_ifs_sel,
  input  logic [2:0]  wshb_ifs_cti,
  input  logic [1:0]  wshb_ifs_bte,
  output logic        wshb_ifs_ack,
  output logic        wshb_ifs_err,
  output logic        wshb_ifs_rty,
  output logic [31:0] wshb_ifs_dat_sm,
  // SDRAM side (initiator)
  output logic        wshb_ifm_cyc,
  output logic        wshb_ifm_stb,
  output logic        wshb_ifm_we,
  output logic [31:0] wshb_ifm_adr,
  output logic [31:0] wshb_ifm_dat_ms,
  output logic [3:0]  wshb_ifm_sel,
  output logic [2:0]  wshb_ifm_cti,
  output logic [1:0]  wshb_ifm_bte,
  input  logic        wshb_ifm_ack,
  input  logic        wshb_ifm_err,
  input  logic        wshb_ifm_rty,
  input  logic [31:0] wshb_ifm_dat_sm,
  output logic        frame_done
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int PW    = $clog2(TOTAL);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state;
  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic [PW-1:0] pix_cnt;
  logic [PW-1:0] idx;
  logic [PW-1:0] idx_next;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          head_sof;
  logic          next_sof;
  logic [31:0]   head_dat;
  logic          unused_inputs;

  assign unused_inputs = ^{wshb_ifs_sel, wshb_ifs_cti, wshb_ifs_bte, wshb_ifm_dat_sm, wshb_ifm_rty, next_sof};

  assign full  = (level == LW'(FIFO_DEPTH));
  assign empty = (level == '0);

  assign wshb_ifs_ack    = wshb_ifs_cyc & wshb_ifs_stb & wshb_ifs_we & ~full;
  assign wshb_ifs_err    = wshb_ifs_cyc & wshb_ifs_stb & ~wshb_ifs_we;
  assign wshb_ifs_rty    = 1'b0;
  assign wshb_ifs_dat_sm = 32'h0;

  assign push = wshb_ifs_ack;
  // rty from SDRAM leaves the head in place, so the same word is re-presented
  assign pop  = (state == WRITE) & (wshb_ifm_ack | wshb_ifm_err);

  assign head_sof   = mem[rd_ptr][32];
  assign head_dat   = mem[rd_ptr][31:0];
  assign next_sof   = mem[rd_ptr + AW'(1)][32];
  assign level_next = level + LW'(push) - LW'(pop);

  assign idx      = head_sof ? '0 : pix_cnt;
  assign idx_next = (idx == PW'(TOTAL - 1)) ? '0 : idx + PW'(1);

  assign wshb_ifm_adr    = (state == WRITE) ? BASE_ADR + (32'(idx) << 2) : 32'h0;
  assign wshb_ifm_dat_ms = (state == WRITE) ? head_dat : 32'h0;
  assign wshb_ifm_bte    = 2'b00;

`ifdef STREAM_SINK_BURST_EN
  // a queued sof word must open its own burst, so the word before it terminates
  assign wshb_ifm_cti = (state != WRITE) ? 3'b000 :
                        ((level > LW'(1)) && !next_sof) ? 3'b010 : 3'b111;
`else
  assign wshb_ifm_cti = 3'b000;
`endif

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {(wshb_ifs_adr == 32'h0), wshb_ifs_dat_ms};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      pix_cnt      <= '0;
      frame_done   <= 1'b0;
      wshb_ifm_cyc <= 1'b0;
      wshb_ifm_stb <= 1'b0;
      wshb_ifm_we  <= 1'b0;
      wshb_ifm_sel <= 4'h0;
    end else begin
      level      <= level_next;
      frame_done <= pop && (idx == PW'(TOTAL - 1));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        pix_cnt <= idx_next;
      end
      case (state)
        IDLE: begin
          if (!empty) begin
            state        <= WRITE;
            wshb_ifm_cyc <= 1'b1;
            wshb_ifm_stb <= 1'b1;
            wshb_ifm_we  <= 1'b1;
            wshb_ifm_sel <= 4'hF;
          end
        end
        WRITE: begin
          if (pop && (level_next == '0)) begin
            state        <= IDLE;
            wshb_ifm_cyc <= 1'b0;
            wshb_ifm_stb <= 1'b0;
            wshb_ifm_we  <= 1'b0;
            wshb_ifm_sel <= 4'h0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_sink.sv
// Directed bench for stream_sink on a 16x8 frame with a nonzero framebuffer base.
`timescale 1ns/1ps
module tb_stream_sink;

  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef STREAM_SINK_BURST_EN
  localparam logic [2:0] CTI_SINGLE = 3'b111;
  localparam logic [2:0] CTI_MID    = 3'b010;
`else
  localparam logic [2:0] CTI_SINGLE = 3'b000;
  localparam logic [2:0] CTI_MID    = 3'b000;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat;
  logic        s_ack, s_err, s_rty;
  logic [31:0] s_dat_sm;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        m_ack, m_err, m_rty;
  logic        frame_done;
  logic        ack_en, rty_en, err_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;
  int fd_count = 0;
  int fd_cyc   = -1;
  logic [31:0] log_adr[$];
  logic [31:0] log_dat[$];
  logic [2:0]  log_cti[$];
  int          log_cyc[$];

  assign m_ack = ack_en & m_cyc & m_stb;
  assign m_rty = rty_en & m_cyc & m_stb;
  assign m_err = err_en & m_cyc & m_stb;

  stream_sink #(.HDISP(16), .VDISP(8), .FIFO_DEPTH(16), .BASE_ADR(BASE)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .wshb_ifs_cyc(s_cyc), .wshb_ifs_stb(s_stb), .wshb_ifs_we(s_we), .wshb_ifs_adr(s_adr),
    .wshb_ifs_dat_ms(s_dat), .wshb_ifs_sel(4'hF), .wshb_ifs_cti(3'b000), .wshb_ifs_bte(2'b00),
    .wshb_ifs_ack(s_ack), .wshb_ifs_err(s_err), .wshb_ifs_rty(s_rty), .wshb_ifs_dat_sm(s_dat_sm),
    .wshb_ifm_cyc(m_cyc), .wshb_ifm_stb(m_stb), .wshb_ifm_we(m_we), .wshb_ifm_adr(m_adr),
    .wshb_ifm_dat_ms(m_dat), .wshb_ifm_sel(m_sel), .wshb_ifm_cti(m_cti), .wshb_ifm_bte(m_bte),
    .wshb_ifm_ack(m_ack), .wshb_ifm_err(m_err), .wshb_ifm_rty(m_rty), .wshb_ifm_dat_sm(32'h0),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // SDRAM-side scoreboard: record every acknowledged master write just before the edge
  always @(negedge clk) begin
    #4;
    if (m_cyc && m_stb && m_ack) begin
      log_adr.push_back(m_adr);
      log_dat.push_back(m_dat);
      log_cti.push_back(m_cti);
      log_cyc.push_back(cyc_cnt);
    end
    if (frame_done === 1'b1) begin
      fd_count++;
      fd_cyc = cyc_cnt;
    end
  end

  task automatic clear_log();
    log_adr.delete(); log_dat.delete(); log_cti.delete(); log_cyc.delete();
    fd_count = 0;
  endtask

  task automatic stream_idle();
    s_cyc = 0; s_stb = 0; s_we = 0;
  endtask

  task automatic stream_write(input logic [31:0] a, input logic [31:0] d, input int budget);
    int k = 0;
    s_cyc = 1; s_stb = 1; s_we = 1; s_adr = a; s_dat = d;
    #1;
    while (!s_ack && k < budget) begin @(negedge clk); #1; k++; end
    n_checks++;
    if (s_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_ack: adr=%h ack=%b after %0d cycles, required 1", a, s_ack, k);
    end
    @(negedge clk);
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_adr.size() < n && k < budget) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_checks++;
    if (log_adr.size() != n) begin
      n_fail++;
      $display("FAIL sdram_count: %0d writes seen, required %0d", log_adr.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1; ack_en = 0; rty_en = 0; err_en = 0;
    s_cyc = 0; s_stb = 0; s_we = 0; s_adr = 0; s_dat = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_sel, m_cti, m_bte, frame_done} !== 13'h0 || m_adr !== 32'h0 || m_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b sel=%h cti=%b bte=%b fd=%b adr=%h dat=%h, required all 0",
               m_cyc, m_stb, m_we, m_sel, m_cti, m_bte, frame_done, m_adr, m_dat);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_single();
    clear_log();
    ack_en = 0;
    stream_write(32'h0, 32'h00FF_0000, 0);
    stream_idle();
    #1;
    n_checks++;
    if (m_cyc !== 1'b0) begin n_fail++; $display("FAIL single_latency: cyc=%b one cycle after push, required 0", m_cyc); end
    @(negedge clk); #1;
    n_checks++;
    if ({m_cyc, m_stb, m_we} !== 3'b111 || m_sel !== 4'hF || m_adr !== BASE || m_dat !== 32'h00FF_0000 || m_cti !== CTI_SINGLE) begin
      n_fail++;
      $display("FAIL single_master: cyc/stb/we=%b sel=%h adr=%h dat=%h cti=%b, required 111 F %h 00ff0000 %b",
               {m_cyc, m_stb, m_we}, m_sel, m_adr, m_dat, m_cti, BASE, CTI_SINGLE);
    end
    ack_en = 1;
    @(negedge clk); #1;
    n_checks++;
    if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin n_fail++; $display("FAIL single_release: cyc=%b stb=%b after ack, required 0", m_cyc, m_stb); end
    stream_write(32'h40, 32'hA1, 20);
    stream_idle();
    wait_log(2, 20);
    n_checks++;
    if (log_adr[1] !== BASE + 32'd4 || log_dat[1] !== 32'hA1) begin
      n_fail++;
      $display("FAIL single_next_adr: adr=%h dat=%h, required %h 000000a1", log_adr[1], log_dat[1], BASE + 32'd4);
    end
  endtask

  task automatic test_backpressure();
    int seen = 0;
    clear_log();
    ack_en = 0;
    for (int i = 0; i < 16; i++) stream_write((i == 0) ? 32'h0 : 32'h100 + 32'(i), 32'hB000_0000 + 32'(i), 0);
    s_adr = 32'h200; s_dat = 32'hB000_0010;
    for (int k = 0; k < 4; k++) begin #1; if (s_ack) seen++; @(negedge clk); end
    ack_en = 1;
    #1; if (s_ack) seen++;
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL full_stall: 17th word acked %0d times while full, required 0", seen); end
    @(negedge clk); #1;
    n_checks++;
    if (s_ack !== 1'b1) begin n_fail++; $display("FAIL full_release: ack=%b after first SDRAM ack, required 1", s_ack); end
    @(negedge clk);
    stream_idle();
    wait_log(17, 60);
    for (int i = 0; i < 17; i++) begin
      n_checks++;
      if (log_adr[i] !== BASE + 32'(4 * i) || log_dat[i] !== 32'hB000_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: adr=%h dat=%h, required %h %h", i, log_adr[i], log_dat[i], BASE + 32'(4 * i), 32'hB000_0000 + 32'(i));
      end
    end
    n_checks++;
    if (log_cyc[16] - log_cyc[0] != 16) begin
      n_fail++;
      $display("FAIL back_to_back: 17 SDRAM writes spanned %0d cycles, required 16", log_cyc[16] - log_cyc[0]);
    end
  endtask

  task automatic test_cti();
    logic [2:0] exp_cti;
    clear_log();
    ack_en = 0;
    for (int i = 0; i < 4; i++) stream_write((i == 0) ? 32'h0 : 32'h8 + 32'(i), 32'hE0 + 32'(i), 20);
    stream_idle();
    ack_en = 1;
    wait_log(4, 20);
    for (int i = 0; i < 4; i++) begin
      exp_cti = (i == 3) ? CTI_SINGLE : CTI_MID;
      n_checks++;
      if (log_cti[i] !== exp_cti || log_dat[i] !== 32'hE0 + 32'(i)) begin
        n_fail++;
        $display("FAIL cti_seq[%0d]: cti=%b dat=%h, required %b %h", i, log_cti[i], log_dat[i], exp_cti, 32'hE0 + 32'(i));
      end
    end
  endtask

  task automatic test_frame();
    clear_log();
    ack_en = 1;
    for (int i = 0; i < 128; i++) stream_write((i == 0) ? 32'h0 : 32'h4 * 32'(i), 32'hF000 + 32'(i), 20);
    stream_write(32'h300, 32'hF0FF, 20);
    stream_idle();
    wait_log(129, 60);
    n_checks++;
    if (fd_count != 1) begin n_fail++; $display("FAIL frame_done_count: %0d pulses, required 1", fd_count); end
    n_checks++;
    if (fd_cyc != log_cyc[127] + 1) begin
      n_fail++;
      $display("FAIL frame_done_time: pulse in cycle %0d, required %0d", fd_cyc, log_cyc[127] + 1);
    end
    n_checks++;
    if (log_adr[127] !== BASE + 32'd508 || log_adr[128] !== BASE || log_dat[128] !== 32'hF0FF) begin
      n_fail++;
      $display("FAIL frame_wrap: last adr=%h next adr=%h dat=%h, required %h %h 0000f0ff",
               log_adr[127], log_adr[128], log_dat[128], BASE + 32'd508, BASE);
    end
  endtask

  task automatic test_mid_sof();
    clear_log();
    ack_en = 1;
    for (int i = 0; i < 100; i++) stream_write((i == 0) ? 32'h0 : 32'h4 * 32'(i), 32'h5000 + 32'(i), 20);
    stream_write(32'h0, 32'h5AAA, 20);
    stream_write(32'h4, 32'h5BBB, 20);
    stream_idle();
    wait_log(102, 40);
    n_checks++;
    if (log_adr[99] !== BASE + 32'd396 || log_adr[100] !== BASE || log_adr[101] !== BASE + 32'd4) begin
      n_fail++;
      $display("FAIL mid_sof: adr99=%h adr100=%h adr101=%h, required %h %h %h",
               log_adr[99], log_adr[100], log_adr[101], BASE + 32'd396, BASE, BASE + 32'd4);
    end
    n_checks++;
    if (fd_count != 0) begin n_fail++; $display("FAIL mid_sof_frame_done: %0d pulses, required 0", fd_count); end
  endtask

  task automatic test_retry_err();
    // per-cycle SDRAM response: 0 ack, 1 retry, 2 error
    int ctl [6] = '{0, 0, 1, 0, 0, 2};
    logic [31:0] exp_dat [5] = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC5};
    logic [31:0] exp_adr [5];
    exp_adr = '{BASE, BASE + 32'd4, BASE + 32'd8, BASE + 32'd12, BASE + 32'd20};
    clear_log();
    ack_en = 0;
    for (int i = 0; i < 6; i++) stream_write((i == 0) ? 32'h0 : 32'h10 + 32'(i), 32'hC0 + 32'(i), 20);
    stream_idle();
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      ack_en = (ctl[s] == 0); rty_en = (ctl[s] == 1); err_en = (ctl[s] == 2);
      #1;
      if (s == 2 || s == 3) begin
        n_checks++;
        if (m_dat !== 32'hC2 || m_adr !== BASE + 32'd8) begin
          n_fail++;
          $display("FAIL retry_represent[%0d]: adr=%h dat=%h, required %h 000000c2", s, m_adr, m_dat, BASE + 32'd8);
        end
      end
      @(negedge clk);
    end
    ack_en = 1; rty_en = 0; err_en = 0;
    wait_log(5, 20);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (log_adr[i] !== exp_adr[i] || log_dat[i] !== exp_dat[i]) begin
        n_fail++;
        $display("FAIL retry_order[%0d]: adr=%h dat=%h, required %h %h", i, log_adr[i], log_dat[i], exp_adr[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_read_err();
    clear_log();
    ack_en = 1;
    s_cyc = 1; s_stb = 1; s_we = 0; s_adr = 32'h10;
    #1;
    n_checks++;
    if (s_err !== 1'b1 || s_ack !== 1'b0 || s_rty !== 1'b0 || s_dat_sm !== 32'h0) begin
      n_fail++;
      $display("FAIL read_err: err=%b ack=%b rty=%b dat=%h, required 1 0 0 0", s_err, s_ack, s_rty, s_dat_sm);
    end
    @(negedge clk);
    stream_idle();
    repeat (4) @(negedge clk);
    n_checks++;
    if (log_adr.size() != 0) begin n_fail++; $display("FAIL read_no_push: %0d SDRAM writes, required 0", log_adr.size()); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    ack_en = 0;
    for (int i = 0; i < 3; i++) stream_write(32'h20 + 32'(i), 32'hD0 + 32'(i), 20);
    stream_idle();
    @(negedge clk);
    rst = 1;
    #1;
    n_checks++;
    if (m_cyc !== 1'b0 || m_stb !== 1'b0) begin n_fail++; $display("FAIL reset_async: cyc=%b stb=%b, required 0 0", m_cyc, m_stb); end
    @(negedge clk);
    rst = 0; ack_en = 1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (log_adr.size() != 0 || m_cyc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flush: %0d writes cyc=%b after reset, required 0 0", log_adr.size(), m_cyc);
    end
    stream_write(32'h44, 32'hD9, 20);
    stream_idle();
    wait_log(1, 20);
    n_checks++;
    if (log_adr[0] !== BASE || log_dat[0] !== 32'hD9) begin
      n_fail++;
      $display("FAIL reset_pix_cnt: adr=%h dat=%h, required %h 000000d9", log_adr[0], log_dat[0], BASE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_cti();
    test_frame();
    test_mid_sof();
    test_retry_err();
    test_read_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
